// File: rtl/mem_stage_if.sv
// Bus bundle for the memory-access stage: execute-side inputs, SRAM data
// response, write-back handshake, and the stage outputs.
interface mem_stage_if;
   logic        exe_to_mem_valid;
   logic        mem_allowin;
   logic [31:0] exe_pc;
   logic [31:0] exe_result;
   logic        exe_res_from_mem;
   logic [7:0]  exe_mem_all;
   logic        exe_mem_req;
   logic [5:0]  exe_rf_all;
   logic [6:0]  exe_exc_rf;
   logic [78:0] exe_csr_rf;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        wb_allowin;
   logic        cancel_exc_ertn;
   logic        mem_to_wb_valid;
   logic [31:0] mem_pc;
   logic [31:0] mem_final_result;
   logic [5:0]  mem_rf_all;
   logic [6:0]  mem_exc_rf;
   logic [78:0] mem_csr_rf;
   logic        mem_exc_flush;
   logic [53:0] mem_fwd_all;

   modport master (
      output exe_to_mem_valid, exe_pc, exe_result, exe_res_from_mem,
             exe_mem_all, exe_mem_req, exe_rf_all, exe_exc_rf, exe_csr_rf,
             data_sram_data_ok, data_sram_rdata, wb_allowin,
             cancel_exc_ertn,
      input  mem_allowin, mem_to_wb_valid, mem_pc, mem_final_result,
             mem_rf_all, mem_exc_rf, mem_csr_rf, mem_exc_flush,
             mem_fwd_all
   );

   modport slave (
      input  exe_to_mem_valid, exe_pc, exe_result, exe_res_from_mem,
             exe_mem_all, exe_mem_req, exe_rf_all, exe_exc_rf, exe_csr_rf,
             data_sram_data_ok, data_sram_rdata, wb_allowin,
             cancel_exc_ertn,
      output mem_allowin, mem_to_wb_valid, mem_pc, mem_final_result,
             mem_rf_all, mem_exc_rf, mem_csr_rf, mem_exc_flush,
             mem_fwd_all
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: waits for data_ok, aligns load data, buffers it
// across write-back stalls and drops responses owed to flushed requests.
module mem_stage (
   input logic       clk,
   input logic       resetn,
   mem_stage_if.slave bus
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] result_q;
   logic        from_mem_q;
   logic [7:0]  mem_all_q;
   logic        req_q;
   logic [5:0]  rf_all_q;
   logic [6:0]  exc_q;
   logic [78:0] csr_q;
   logic        buf_valid_q;
   logic [31:0] buf_data_q;
   logic [1:0]  discard_q;
   logic [1:0]  discard_d;

   logic        data_ok_now;
   logic        ready_go;
   logic        allowin;
   logic        latch;
   logic        buf_cap;
   logic        leave;
   logic        load_pending;
   logic [1:0]  owed;
   logic [2:0]  disc_sum;

   logic [31:0] raw;
   logic [31:0] sh;
   logic [15:0] half;
   logic [31:0] ld_val;
   logic [31:0] final_res;
   logic [1:0]  a;
   logic        se;

   assign data_ok_now = bus.data_sram_data_ok & (discard_q == 2'd0);
   assign ready_go    = ~req_q | buf_valid_q | data_ok_now;
   assign allowin     = ~valid_q | (ready_go & bus.wb_allowin);
   assign latch       = bus.exe_to_mem_valid & allowin;
   assign leave       = valid_q & ready_go & bus.wb_allowin;
   assign buf_cap     = data_ok_now & valid_q & req_q & ~buf_valid_q
                      & ~bus.wb_allowin;
   assign load_pending = valid_q & from_mem_q & ~ready_go;

   // Responses still in flight at a flush must be swallowed later.
   always_comb begin
      owed = {1'b0, valid_q & req_q & ~buf_valid_q & ~data_ok_now}
           + {1'b0, bus.exe_mem_req & bus.exe_to_mem_valid};
      disc_sum = {1'b0, discard_q}
               - {2'b00, bus.data_sram_data_ok & (discard_q != 2'd0)}
               + (bus.cancel_exc_ertn ? {1'b0, owed} : 3'd0);
      discard_d = (disc_sum > 3'd3) ? 2'd3 : disc_sum[1:0];
   end

   always_comb begin
      a      = result_q[1:0];
      se     = mem_all_q[3];
      raw    = buf_valid_q ? buf_data_q : bus.data_sram_rdata;
      sh     = raw >> {a, 3'b000};
      half   = a[1] ? raw[31:16] : raw[15:0];
      ld_val = raw;
      unique case (1'b1)
         mem_all_q[6]: ld_val = {{24{se & sh[7]}}, sh[7:0]};
         mem_all_q[5]: ld_val = {{16{se & half[15]}}, half};
         default:      ld_val = raw;
      endcase
      final_res = from_mem_q ? ld_val : result_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         result_q    <= '0;
         from_mem_q  <= 1'b0;
         mem_all_q   <= '0;
         req_q       <= 1'b0;
         rf_all_q    <= '0;
         exc_q       <= '0;
         csr_q       <= '0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
         discard_q   <= 2'd0;
      end else begin
         if (bus.cancel_exc_ertn)
            valid_q <= 1'b0;
         else if (allowin)
            valid_q <= bus.exe_to_mem_valid;
         if (latch) begin
            pc_q       <= bus.exe_pc;
            result_q   <= bus.exe_result;
            from_mem_q <= bus.exe_res_from_mem;
            mem_all_q  <= bus.exe_mem_all;
            req_q      <= bus.exe_mem_req;
            rf_all_q   <= bus.exe_rf_all;
            exc_q      <= bus.exe_exc_rf;
            csr_q      <= bus.exe_csr_rf;
         end
         if (bus.cancel_exc_ertn | latch)
            buf_valid_q <= 1'b0;
         else if (buf_cap) begin
            buf_valid_q <= 1'b1;
            buf_data_q  <= bus.data_sram_rdata;
         end else if (leave)
            buf_valid_q <= 1'b0;
         discard_q <= discard_d;
      end
   end

   assign bus.mem_allowin      = allowin;
   assign bus.mem_to_wb_valid  = valid_q & ready_go;
   assign bus.mem_pc           = pc_q;
   assign bus.mem_final_result = final_res;
   assign bus.mem_rf_all       = rf_all_q;
   assign bus.mem_exc_rf       = exc_q;
   assign bus.mem_csr_rf       = csr_q;
   assign bus.mem_exc_flush    = valid_q & ((|exc_q) | csr_q[78]);
   assign bus.mem_fwd_all = valid_q
      ? {csr_q[77], csr_q[76:63], load_pending, rf_all_q, final_res}
      : 54'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads, stores, stalls,
// flush/discard and exception pass-through.
module tb_mem_stage;

   logic clk;
   logic resetn;
   int   errors;
   int   checks;
   logic [63:0] sb[$];

   mem_stage_if bus ();

   mem_stage dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every instruction handed to write-back is popped and compared.
   always @(negedge clk) begin
      if (resetn && bus.mem_to_wb_valid && bus.wb_allowin) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: pc %h with no expected entry",
                     bus.mem_pc);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("wb_pc", bus.mem_pc, e[63:32]);
            chk("wb_result", bus.mem_final_result, e[31:0]);
         end
      end
   end

   task automatic do_mem(input logic [31:0] pc, input logic [31:0] addr,
                         input logic rfm, input logic [7:0] ma,
                         input logic [31:0] rd, input int waits,
                         input logic [31:0] expv);
      bus.exe_pc           = pc;
      bus.exe_result       = addr;
      bus.exe_res_from_mem = rfm;
      bus.exe_mem_all      = ma;
      bus.exe_mem_req      = 1'b1;
      bus.exe_rf_all       = 6'b100101;
      bus.exe_exc_rf       = '0;
      bus.exe_to_mem_valid = 1'b1;
      sb.push_back({pc, expv});
      tick();
      bus.exe_to_mem_valid = 1'b0;
      bus.exe_mem_req      = 1'b0;
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         chk("wait_lp", bus.mem_fwd_all[38], rfm);
         chk("wait_allowin", bus.mem_allowin, 0);
         chk("wait_towb", bus.mem_to_wb_valid, 0);
         tick();
      end
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = rd;
      @(negedge clk);
      chk("ok_towb", bus.mem_to_wb_valid, 1);
      chk("ok_allowin", bus.mem_allowin, 1);
      chk("ok_fwd_rf", bus.mem_fwd_all[37:32], 6'b100101);
      tick();
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = 32'hA5A5_5A5A;
      @(negedge clk);
      chk("after_towb", bus.mem_to_wb_valid, 0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      resetn = 1'b0;
      bus.exe_to_mem_valid  = 1'b0;
      bus.exe_pc            = '0;
      bus.exe_result        = '0;
      bus.exe_res_from_mem  = 1'b0;
      bus.exe_mem_all       = '0;
      bus.exe_mem_req       = 1'b0;
      bus.exe_rf_all        = '0;
      bus.exe_exc_rf        = '0;
      bus.exe_csr_rf        = '0;
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = '0;
      bus.wb_allowin        = 1'b1;
      bus.cancel_exc_ertn   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_allowin", bus.mem_allowin, 1);
      chk("rst_towb", bus.mem_to_wb_valid, 0);
      chk("rst_pc", bus.mem_pc, 0);
      chk("rst_result", bus.mem_final_result, 0);
      chk("rst_flush", bus.mem_exc_flush, 0);
      chk("rst_fwd", {31'd0, |bus.mem_fwd_all}, 0);
      chk("rst_discard", {30'd0, dut.discard_q}, 0);
      resetn = 1'b1;

      // ld_w, response in first cycle
      do_mem(32'h100, 32'h1000, 1, 8'b0001_0000, 32'h89AB_CDEF, 0,
             32'h89AB_CDEF);
      // ld_b signed / unsigned, offset 3
      do_mem(32'h104, 32'h1003, 1, 8'b0100_1000, 32'h80FF_0011, 0,
             32'hFFFF_FF80);
      do_mem(32'h108, 32'h1003, 1, 8'b0100_0000, 32'h80FF_0011, 0,
             32'h0000_0080);
      // ld_h, offset 2, three wait cycles
      do_mem(32'h10C, 32'h2002, 1, 8'b0010_0000, 32'h7FFE_1234, 3,
             32'h0000_7FFE);
      // store with accepted request waits one cycle
      do_mem(32'h110, 32'h2008, 0, 8'b1000_0001, 32'h0, 1, 32'h2008);

      // data_ok while write-back stalls: data must be buffered
      bus.exe_pc = 32'h200;
      bus.exe_result = 32'h3000;
      bus.exe_res_from_mem = 1'b1;
      bus.exe_mem_all = 8'b0001_0000;
      bus.exe_mem_req = 1'b1;
      bus.exe_to_mem_valid = 1'b1;
      sb.push_back({32'h200, 32'h1122_3344});
      tick();
      bus.exe_to_mem_valid = 1'b0;
      bus.exe_mem_req = 1'b0;
      bus.wb_allowin = 1'b0;
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata = 32'h1122_3344;
      @(negedge clk);
      chk("stall_allowin", bus.mem_allowin, 0);
      tick();
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata = 32'h5566_7788;
      @(negedge clk);
      chk("buf_valid", {31'd0, dut.buf_valid_q}, 1);
      chk("buf_result", bus.mem_final_result, 32'h1122_3344);
      tick();
      bus.wb_allowin = 1'b1;
      @(negedge clk);
      chk("buf_towb", bus.mem_to_wb_valid, 1);
      tick();
      @(negedge clk);
      chk("buf_clear", {31'd0, dut.buf_valid_q}, 0);

      // flush while a load waits: its late response is dropped
      bus.exe_pc = 32'h300;
      bus.exe_result = 32'h4000;
      bus.exe_mem_req = 1'b1;
      bus.exe_to_mem_valid = 1'b1;
      tick();
      bus.exe_to_mem_valid = 1'b0;
      bus.exe_mem_req = 1'b0;
      bus.cancel_exc_ertn = 1'b1;
      tick();
      bus.cancel_exc_ertn = 1'b0;
      @(negedge clk);
      chk("cancel_towb", bus.mem_to_wb_valid, 0);
      chk("cancel_allowin", bus.mem_allowin, 1);
      chk("cancel_discard", {30'd0, dut.discard_q}, 1);
      tick();
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("drop_towb", bus.mem_to_wb_valid, 0);
      tick();
      bus.data_sram_data_ok = 1'b0;
      @(negedge clk);
      chk("drop_discard", {30'd0, dut.discard_q}, 0);
      do_mem(32'h304, 32'h4004, 1, 8'b0001_0000, 32'h0000_0005, 0,
             32'h0000_0005);

      // ALE exception, no request: passes in one cycle and flushes
      bus.exe_pc = 32'h400;
      bus.exe_result = 32'h1002;
      bus.exe_res_from_mem = 1'b0;
      bus.exe_mem_all = 8'b1000_0001;
      bus.exe_mem_req = 1'b0;
      bus.exe_exc_rf = 7'b001_0000;
      bus.exe_to_mem_valid = 1'b1;
      sb.push_back({32'h400, 32'h1002});
      tick();
      bus.exe_to_mem_valid = 1'b0;
      bus.exe_exc_rf = '0;
      @(negedge clk);
      chk("exc_towb", bus.mem_to_wb_valid, 1);
      chk("exc_flush", bus.mem_exc_flush, 1);
      tick();
      @(negedge clk);
      chk("exc_flush_off", bus.mem_exc_flush, 0);

      tick();
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, between the execute stage and the write-back stage. It latches the instruction the execute stage hands over, waits for the SRAM-like data interface's `data_ok` response, aligns and sign-extends load data, and buffers that data while write-back stalls. It discards responses belonging to requests cancelled by an exception or `ertn`, and publishes forwarding and exception-flush information back to the execute and decode stages.

## Interface
Parameters: none.
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- exe_to_mem_valid  in  1  execute stage has a finished instruction
- mem_allowin  out  1  stage can accept an instruction this cycle
- exe_pc  in  32  instruction PC
- exe_result  in  32  ALU result / data address
- exe_res_from_mem  in  1  instruction is a load
- exe_mem_all  in  8  {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
- exe_mem_req  in  1  a data request was actually accepted (`addr_ok`) for this instruction
- exe_rf_all  in  6  {rf_we, rf_waddr[4:0]}
- exe_exc_rf  in  7  exception flags; bit 4 = ALE
- exe_csr_rf  in  79  {csr_rd, csr_wr, csr_wr_num[13:0], csr payload}
- data_sram_data_ok  in  1  response strobe, one per accepted request, in order
- data_sram_rdata  in  32  response data, valid with `data_ok`
- wb_allowin  in  1  write-back stage can accept
- cancel_exc_ertn  in  1  pipeline flush from write-back
- mem_to_wb_valid  out  1  valid toward write-back
- mem_pc  out  32  latched PC
- mem_final_result  out  32  load data after alignment, else latched `exe_result`
- mem_rf_all  out  6  latched {rf_we, rf_waddr}
- mem_exc_rf  out  7  latched exception flags
- mem_csr_rf  out  79  latched CSR bundle
- mem_exc_flush  out  1  `mem_valid & (|mem_exc_rf | csr_rd bit)`; execute stage suppresses new requests while high
- mem_fwd_all  out  54  {csr_wr, csr_wr_num, load_pending, rf_we, rf_waddr, mem_final_result}, all-zero when `!mem_valid`

## Operation
- Pipeline register: on `exe_to_mem_valid & mem_allowin`, latch all `exe_*` fields, set `mem_req_r = exe_mem_req`, and clear `buf_valid`. Otherwise all fields hold.
- `mem_valid`: cleared by reset or `cancel_exc_ertn`; otherwise on `mem_allowin` it loads `exe_to_mem_valid`.
- `mem_ready_go = ~mem_req_r | buf_valid | (data_sram_data_ok & (discard_cnt == 0))`.
- `mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin)`.
- `mem_to_wb_valid = mem_valid & mem_ready_go`.
- Data buffer: `data_ok` with `discard_cnt == 0` and `mem_valid & mem_req_r & ~buf_valid` and `~wb_allowin` captures `rdata` into `buf_data` and sets `buf_valid`. `buf_valid` clears when the instruction leaves.
- Raw data: `raw = buf_valid ? buf_data : data_sram_rdata`.
- Alignment, offset `a = mem_result[1:0]`:
  - ld_b: byte `raw[8a+7:8a]`.
  - ld_h: halfword `raw[31:16]` if `a[1]`, else `raw[15:0]`.
  - ld_w: `raw`.
  - Sign-extend when `ld_se`, else zero-extend.
  - Non-loads use `mem_result` unchanged.
- Discard counter (`discard_cnt`, 2 bits):
  - On `cancel_exc_ertn`, set `discard_cnt` to the number of responses still owed. This is `mem_valid & mem_req_r & ~buf_valid & ~data_ok_now`, plus 1 if the execute stage's request was accepted this cycle (`exe_mem_req & exe_to_mem_valid`).
  - Each `data_ok` while `discard_cnt != 0` decrements it and the data is dropped.
  - Simultaneous `data_ok` and increment: net value.
  - `discard_cnt` saturates at 3.
- `load_pending = mem_valid & exe_res_from_mem_r & ~mem_ready_go`. Decode stalls consumers while it is high.

## Timing
- Reset values: `mem_valid` 0, `buf_valid` 0, `discard_cnt` 0; `mem_pc`, `mem_final_result`, `mem_rf_all`, `mem_exc_rf`, `mem_csr_rf` all 0; `mem_to_wb_valid`, `mem_exc_flush`, `mem_fwd_all` 0; `mem_allowin` 1.
- `data_ok` arrives at the earliest the cycle after `addr_ok`, i.e. the first cycle `mem_valid` is high. Load-to-WB latency is 0 extra cycles when `data_ok` arrives in that cycle, and N extra cycles for N wait cycles.
- Store (mem_we) with `exe_mem_req = 1` also waits for its `data_ok`.
- An instruction with an exception (`exe_mem_req = 0`) passes in 1 cycle.
- `cancel_exc_ertn` wins over a simultaneous latch; the incoming instruction is dropped.
- A reset mid-wait clears `discard_cnt`. The external SRAM is reset together with the stage.

## Test plan
- ld_w, `exe_result = 0x1000`, `data_ok` in the first cycle with `rdata = 0x89ABCDEF` -> `mem_to_wb_valid` for 1 cycle, `mem_final_result = 0x89ABCDEF`, `mem_allowin` stays 1.
- ld_b with `ld_se`, `a = 3`, `rdata = 0x80FF0011` -> result `0xFFFFFF80`. The same case with `ld_se = 0` -> `0x00000080`.
- ld_h, `a = 2`, `data_ok` delayed 3 cycles, `rdata = 0x7FFE1234` -> `load_pending` 1 for 3 cycles, `mem_allowin` 0, then result `0x00007FFE`.
- Load gets `data_ok` while `wb_allowin = 0` for 2 cycles, and `rdata` changes afterwards -> `buf_valid` is set and the result equals the first `rdata`.
- `cancel_exc_ertn` while a load waits -> `mem_valid` 0 next cycle and `discard_cnt = 1`. The following `data_ok` with `0xDEADBEEF` is dropped. The next load's `data_ok` with `0x00000005` yields 5.
- Instruction with `exe_exc_rf[4] = 1` and `exe_mem_req = 0` -> `mem_exc_flush = 1` for the cycle it is valid, and it passes with no `data_ok` awaited.
